add_seq: RTL and testbench

- Parametrised multi-cycle successor to the 16-bit combinational add16.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, rippling carry through a register, and returns sum and carry-out.
- Uses valid/ready handshakes on input and output so it can sit between the Hack CPU datapath and slower or wider arithmetic consumers.
- Trades latency for a short critical path.

---
 rtl/hack_arith_pkg.sv | 22 ++
 rtl/add_chunk.sv | 33 +++
 rtl/add_seq.sv | 174 +++++++++++++++++
 tb/tb_add_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hack_arith_pkg.sv
// Shared arithmetic definitions for the sequential Hack adder.
//   state_e     : controller states (IDLE, RUN, DONE)
//   num_chunks  : number of CHUNK-bit slices in a WIDTH-bit operand
//   idx_width   : width of the chunk index counter, never less than 1
package hack_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int num_chunks(input int width, input int chunk);
        if (chunk < 1 || width < chunk) return 1;
        return width / chunk;
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit adder slice.
//   a, b     : chunk operands
//   cin      : carry into bit 0
//   sum      : chunk sum
//   cout     : carry out of the top bit
//   msb_cin  : carry into the top bit (only with ADD_SEQ_FLAGS_EN, used
//              for signed-overflow detection)
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
`ifdef ADD_SEQ_FLAGS_EN
    ,
    output logic             msb_cin
`endif
);

    logic [CHUNK:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum  = full[CHUNK-1:0];
    assign cout = full[CHUNK];

`ifdef ADD_SEQ_FLAGS_EN
    // The sum bit is a ^ b ^ carry-in, so the carry-in falls back out.
    assign msb_cin = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];
`endif

endmodule

// File: rtl/add_seq.sv
// Multi-cycle add/subtract unit, CHUNK bits per clock with a registered
// ripple carry. Valid/ready handshake on both sides, one operation at a time.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, sub, cin)
//   out_valid / out_ready: result handshake (sum, cout)
//   sub                  : 1 = a - b (cin ignored), 0 = a + b + cin
//   cout                 : final carry; for subtract, 1 = no borrow
// Optional macro ADD_SEQ_FLAGS_EN adds zr / ng / ovf result flags.
module add_seq
    import hack_arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADD_SEQ_FLAGS_EN
    ,
    output logic             zr,
    output logic             ng,
    output logic             ovf
`endif
);

    localparam int N  = num_chunks(WIDTH, CHUNK);
    localparam int IW = idx_width(N);

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("add_seq: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_e                    state_q, state_d;
    logic [N-1:0][CHUNK-1:0]   a_q, a_d;
    logic [N-1:0][CHUNK-1:0]   b_q, b_d;
    logic [N-1:0][CHUNK-1:0]   sum_q, sum_d;
    logic                      carry_q, carry_d;
    logic                      cout_q, cout_d;
    logic [IW-1:0]             idx_q, idx_d;

    logic [CHUNK-1:0]          ca, cb, cs;
    logic                      c_cout;
    logic                      last;

`ifdef ADD_SEQ_FLAGS_EN
    logic zr_q, zr_d, ng_q, ng_d, ovf_q, ovf_d;
    logic c_msb_cin;
`endif

    assign last = (idx_q == IW'(N - 1));

    // Single adder slice, fed from whichever chunk idx points at.
    always_comb begin
        ca = '0;
        cb = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IW'(i)) begin
                ca = a_q[i];
                cb = b_q[i];
            end
        end
    end

    add_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a       (ca),
        .b       (cb),
        .cin     (carry_q),
        .sum     (cs),
        .cout    (c_cout)
`ifdef ADD_SEQ_FLAGS_EN
        ,
        .msb_cin (c_msb_cin)
`endif
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
`ifdef ADD_SEQ_FLAGS_EN
        zr_d    = zr_q;
        ng_d    = ng_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract is a + ~b + 1: invert b, force carry-in.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IW'(i)) sum_d[i] = cs;
                end
                carry_d = c_cout;
                idx_d   = idx_q + 1'b1;
                if (last) begin
                    cout_d  = c_cout;
                    state_d = DONE;
`ifdef ADD_SEQ_FLAGS_EN
                    zr_d    = (sum_d == '0);
                    ng_d    = sum_d[N-1][CHUNK-1];
                    ovf_d   = c_msb_cin ^ c_cout;
`endif
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef ADD_SEQ_FLAGS_EN
            zr_q    <= 1'b0;
            ng_q    <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
`ifdef ADD_SEQ_FLAGS_EN
            zr_q    <= zr_d;
            ng_q    <= ng_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef ADD_SEQ_FLAGS_EN
    assign zr        = zr_q;
    assign ng        = ng_q;
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_add_seq.sv
module tb_add_seq;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, sub = 1'b0, cin = 1'b0, out_ready = 1'b1;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout;
    logic [15:0] sum;

    logic        v32 = 1'b0, or32 = 1'b1;
    logic [31:0] a32 = '0, b32 = '0;
    logic        r32, ov32, c32;
    logic [31:0] s32;

`ifdef ADD_SEQ_FLAGS_EN
    logic zr, ng, ovf, zr32, ng32, ovf32;
`endif

    always #5 clk = ~clk;

    add_seq #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef ADD_SEQ_FLAGS_EN
        , .zr(zr), .ng(ng), .ovf(ovf)
`endif
    );

    add_seq #(.WIDTH(32), .CHUNK(32)) u_dut32 (
        .clk(clk), .reset(reset), .in_valid(v32), .in_ready(r32),
        .a(a32), .b(b32), .sub(1'b0), .cin(1'b0), .out_valid(ov32),
        .out_ready(or32), .sum(s32), .cout(c32)
`ifdef ADD_SEQ_FLAGS_EN
        , .zr(zr32), .ng(ng32), .ovf(ovf32)
`endif
    );

    int total = 0;
    int bad   = 0;
    bit go    = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Reference model: transaction-level view of the unit. An accepted
    // operation produces its result N edges later; the result is computed
    // with plain integer arithmetic.
    bit          m_busy = 1'b0, m_done = 1'b0;
    int          m_cnt = 0;
    logic [15:0] m_sum = '0;
    bit          m_cout = 1'b0, m_zr = 1'b0, m_ng = 1'b0, m_ovf = 1'b0;

    always @(posedge clk) begin
        int sa, sb, t;
        if (reset) begin
            m_busy = 0; m_done = 0; m_sum = '0; m_cout = 0;
            m_zr = 0; m_ng = 0; m_ovf = 0;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin m_busy = 0; m_done = 1; end
        end else if (m_done) begin
            if (out_ready) m_done = 0;
        end else if (in_valid) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sub) begin
                m_sum  = a - b;
                m_cout = (a >= b);
                t      = sa - sb;
            end else begin
                {m_cout, m_sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
                t      = sa + sb + int'(cin);
            end
            m_zr   = (m_sum == 16'd0);
            m_ng   = m_sum[15];
            m_ovf  = (t > 32767) || (t < -32768);
            m_busy = 1;
            m_cnt  = N;
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("in_ready", in_ready, !(m_busy || m_done));
            chk("out_valid", out_valid, m_done);
            if (m_done) begin
                chk("model sum", sum, m_sum);
                chk("model cout", cout, m_cout);
`ifdef ADD_SEQ_FLAGS_EN
                chk("model zr", zr, m_zr);
                chk("model ng", ng, m_ng);
                chk("model ovf", ovf, m_ovf);
`endif
            end
        end
    end

    // Called on a negedge; issues one operation and checks the result
    // against hand-computed literals. efl = {zr, ng, ovf}.
    task automatic do_op(input string nm, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic ts, input logic tc, input logic [15:0] es,
                         input logic ec, input logic [2:0] efl);
        int lat;
        chk({nm, " ready"}, in_ready, 1'b1);
        a = ta; b = tb_; sub = ts; cin = tc; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, lat, N);
        chk({nm, " sum"}, sum, es);
        chk({nm, " cout"}, cout, ec);
`ifdef ADD_SEQ_FLAGS_EN
        chk({nm, " flags"}, {zr, ng, ovf}, efl);
`else
        if (efl === 3'bxxx) $display("flags %b", efl);
`endif
        @(negedge clk);
        chk({nm, " drained"}, out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        @(negedge clk);
        @(negedge clk);
        go = 1'b1;
        reset = 1'b0;
        chk("reset sum", sum, 16'h0000);
        chk("reset cout", cout, 1'b0);
        chk("reset in_ready", in_ready, 1'b1);
        chk("reset out_valid", out_valid, 1'b0);
        @(negedge clk);

        do_op("ffff+1",    16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 3'b100);
        do_op("aaaa+5555", 16'hAAAA, 16'h5555, 0, 0, 16'hFFFF, 0, 3'b010);
        do_op("ffff+ffff+1", 16'hFFFF, 16'hFFFF, 0, 1, 16'hFFFF, 1, 3'b010);
        do_op("1234-4321", 16'h1234, 16'h4321, 1, 0, 16'hCF13, 0, 3'b010);
        do_op("4321-1234", 16'h4321, 16'h1234, 1, 1, 16'h30ED, 1, 3'b000);
        do_op("7fff+1",    16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 3'b011);
        do_op("5-5",       16'h0005, 16'h0005, 1, 0, 16'h0000, 1, 3'b100);

        // Backpressure with a second request held pending.
        out_ready = 1'b0;
        a = 16'h0003; b = 16'h0004; sub = 0; cin = 0; in_valid = 1'b1;
        @(negedge clk);
        a = 16'h0010; b = 16'h0020;
        lat = 0;
        while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
        chk("bp latency", lat, N);
        for (int i = 0; i < 3; i++) begin
            chk("bp sum hold", sum, 16'h0007);
            chk("bp cout hold", cout, 1'b0);
            chk("bp in_ready", in_ready, 1'b0);
            chk("bp out_valid", out_valid, 1'b1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp idle ready", in_ready, 1'b1);
        chk("bp idle valid", out_valid, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp 2nd accepted", in_ready, 1'b0);
        lat = 0;
        while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
        chk("bp 2nd latency", lat, N);
        chk("bp 2nd sum", sum, 16'h0030);
        @(negedge clk);

        // Reset while RUN is on chunk 2.
        a = 16'h1111; b = 16'h2222; sub = 0; cin = 0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort out_valid", out_valid, 1'b0);
        chk("abort sum", sum, 16'h0000);
        chk("abort cout", cout, 1'b0);
        chk("abort in_ready", in_ready, 1'b1);
        repeat (6) @(negedge clk);
        chk("abort no result", out_valid, 1'b0);
        do_op("1+1 after abort", 16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 3'b000);

        // Single-chunk configuration.
        chk("n1 ready", r32, 1'b1);
        a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; v32 = 1'b1;
        @(negedge clk);
        v32 = 1'b0;
        lat = 0;
        while (!ov32 && lat < 40) begin @(negedge clk); lat++; end
        chk("n1 latency", lat, 1);
        chk("n1 sum", s32, 32'h0000_0000);
        chk("n1 cout", c32, 1'b1);
`ifdef ADD_SEQ_FLAGS_EN
        chk("n1 flags", {zr32, ng32, ovf32}, 3'b100);
`endif
        @(negedge clk);
        chk("n1 drained", ov32, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
